// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor,
//   one quotient bit per clock. It returns a 2N-bit quotient, an N-bit
//   remainder and a divide-by-zero flag.
//   Input and output each use a valid/ready handshake. The block accepts a new
//   operation only in IDLE. A result is held until the consumer takes it.
//
//   Optional feature macro: FAST_ZERO_EN
//     Defined   - when divisor==0 or dividend==0, the accept edge goes straight
//                 to DONE with the same result the full run would produce.
//     Undefined - every operation takes the full 2N iterations.
module seq_restoring_divider #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero
);

  localparam int W2 = 2 * N;
  localparam int CW = $clog2(W2 + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W2-1:0]   q_sr;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [N-1:0]    p_reg;     // partial remainder; always fits N bits between iterations
  logic [N-1:0]    div_reg;   // divisor latched at accept
  logic [CW-1:0]   count;     // iterations still to run

  logic [N:0]      p_shift;
  logic            take;
  logic [N:0]      p_next;
  logic [W2-1:0]   q_next;
  logic            accept;
  logic            fast_zero;

  assign accept = in_valid && in_ready;

`ifdef FAST_ZERO_EN
  assign fast_zero = (divisor == '0) || (dividend == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into P, then subtract the divisor if it fits.
  // NOTE: every variable assigned here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    p_shift = {p_reg, q_sr[W2-1]};
    take    = 1'b0;
    p_next  = p_shift;
    if (p_shift >= {1'b0, div_reg}) begin
      take   = 1'b1;
      p_next = p_shift - {1'b0, div_reg};
    end
    q_next = {q_sr[W2-2:0], take};
  end

  // Control FSM, datapath registers and registered handshake/result outputs.
  // NOTE: state registers use non-blocking assignments, so every register in this block samples its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_sr        <= '0;
      p_reg       <= '0;
      div_reg     <= '0;
      count       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (fast_zero) begin
              // A zero divisor keeps every subtraction, so the quotient is all ones
              // and P ends up holding the low N dividend bits.
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= (divisor == '0) ? '1 : '0;
              remainder   <= (divisor == '0) ? dividend[N-1:0] : '0;
              div_by_zero <= (divisor == '0);
            end else begin
              state   <= RUN;
              q_sr    <= dividend;
              div_reg <= divisor;
              p_reg   <= '0;
              count   <= CW'(W2);
            end
          end
        end

        RUN: begin
          // The top bit of P' is dropped after the step. After a subtraction the
          // result is below the divisor. With a zero divisor that bit is shifted
          // out on the next iteration anyway.
          p_reg <= p_next[N-1:0];
          q_sr  <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= q_next;
            remainder   <= p_next[N-1:0];
            div_by_zero <= (div_reg == '0);
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
//   Directed bench for seq_restoring_divider (N=16). It covers reset values,
//   hand-computed quotient/remainder vectors, the zero-divisor result,
//   back-pressure, mid-run reset and a short batch of random pairs.
//   Latency is the number of post-edge samples after the accept edge until
//   out_valid is seen high.
module tb_seq_restoring_divider;

  localparam int N = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*N-1:0]  dividend;
  logic [N-1:0]    divisor;
  logic            out_valid;
  logic            out_ready;
  logic [2*N-1:0]  quotient;
  logic [N-1:0]    remainder;
  logic            div_by_zero;

  int checks;
  int errors;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [2*N-1:0] a, input logic [N-1:0] b);
`ifdef FAST_ZERO_EN
    if (a == '0 || b == '0) return 1;
`endif
    return 2 * N;
  endfunction

  // Present operands, wait (bounded) for in_ready, and complete the accept edge.
  task automatic start_op(input string name, input logic [2*N-1:0] a, input logic [N-1:0] b);
    int n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s.accept_ready", name), 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count samples after the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic check_result(input string name, input logic [2*N-1:0] eq,
                              input logic [N-1:0] er, input logic edz);
    check($sformatf("%s.valid", name), 64'(out_valid), 64'd1);
    check($sformatf("%s.quotient", name), 64'(quotient), 64'(eq));
    check($sformatf("%s.remainder", name), 64'(remainder), 64'(er));
    check($sformatf("%s.div_by_zero", name), 64'(div_by_zero), 64'(edz));
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check($sformatf("%s.drain_valid", name), 64'(out_valid), 64'd0);
    check($sformatf("%s.drain_ready", name), 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [2*N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] eq, input logic [N-1:0] er, input logic edz);
    int lat;
    start_op(name, a, b);
    if (exp_latency(a, b) > 1)
      check($sformatf("%s.busy_ready", name), 64'(in_ready), 64'd0);
    wait_done(lat);
    check($sformatf("%s.latency", name), 64'(lat), 64'(exp_latency(a, b)));
    check_result(name, eq, er, edz);
    drain(name);
  endtask

  initial begin
    int lat;
    logic [2*N-1:0] ra;
    logic [N-1:0]   rb;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset values
    #12;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.quotient", 64'(quotient), 64'd0);
    check("reset.remainder", 64'(remainder), 64'd0);
    check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_op("t1", 32'd1000000, 16'd7, 32'd142857, 16'd1, 1'b0);
    run_op("t2", 32'hFFFFFFFF, 16'hFFFF, 32'h00010001, 16'h0000, 1'b0);
    run_op("t3", 32'h12345678, 16'h0000, 32'hFFFFFFFF, 16'h5678, 1'b1);
    run_op("rmax", 32'hFFFEFFFF, 16'hFFFF, 32'h0000FFFF, 16'hFFFE, 1'b0);
    run_op("div1", 32'hFFFFFFFF, 16'h0001, 32'hFFFFFFFF, 16'h0000, 1'b0);
    run_op("small", 32'd5, 16'd10, 32'd0, 16'd5, 1'b0);
    run_op("zero_num", 32'd0, 16'd5, 32'd0, 16'd0, 1'b0);
    run_op("msb", 32'h80000000, 16'h0002, 32'h40000000, 16'h0000, 1'b0);

    // Back-pressure: the result stays put and a second operation waits
    start_op("bp", 32'd1000000, 16'd7);
    wait_done(lat);
    check("bp.latency", 64'(lat), 64'd32);
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 16'd10;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp.stall_valid", 64'(out_valid), 64'd1);
      check("bp.stall_in_ready", 64'(in_ready), 64'd0);
      check("bp.stall_quotient", 64'(quotient), 64'd142857);
      check("bp.stall_remainder", 64'(remainder), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp.release_valid", 64'(out_valid), 64'd0);
    check("bp.release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp.second_busy", 64'(in_ready), 64'd0);
    wait_done(lat);
    check("bp.second_latency", 64'(lat), 64'd32);
    check_result("bp.second", 32'd100, 16'd0, 1'b0);
    drain("bp.second");

    // Reset in the middle of a run
    start_op("rst", 32'd1000000, 16'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.quotient", 64'(quotient), 64'd0);
    check("rst.remainder", 64'(remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t5", 32'd100, 16'd3, 32'd33, 16'd1, 1'b0);

    // Random pairs checked against native arithmetic
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = 16'($urandom);
      if (i % 4 == 0) ra = ra >> 20;
      if (rb == '0) rb = 16'd1;
      run_op($sformatf("rnd%0d", i), ra, rb, ra / {16'd0, rb}, 16'(ra % {16'd0, rb}), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
